dsm_decimator: RTL and testbench

Third-order CIC decimator that converts a 1-bit delta-sigma bitstream into signed PCM words. It is the receive-side counterpart of the delta-sigma modulator: it sits after a 1-bit source (modulator loopback or external bitstream) and produces one `WIDTH`-bit sample per `2**DEC_LOG2` accepted bits. Full-scale +1 maps to the top of the output range and full-scale −1 maps to the bottom.

---
 rtl/dsm_decimator.sv | 185 ++++++++++++++++++
 tb/tb_dsm_decimator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dsm_decimator.sv
// -----------------------------------------------------------------------------
// dsm_decimator
//   Third-order CIC decimator. It turns a 1-bit delta-sigma bitstream into
//   signed PCM words and emits one WIDTH-bit sample per 2**DEC_LOG2 accepted
//   bits. Full-scale +1 maps to the top of the output range and full-scale -1
//   maps to the bottom.
//
// Parameters
//   WIDTH     output sample width (signed two's complement)
//   DEC_LOG2  log2 of the decimation ratio R (>= 2, 3*DEC_LOG2 >= WIDTH-1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low (0 = reset)
//   in_valid   in_bit is accepted on any edge where this is 1
//   in_bit     bitstream sample, 1 = +1, 0 = -1
//   out        decimated sample (signed), holds between strobes
//   out_valid  one-cycle strobe, high when out has just been updated
//
// Build option
//   DSM_DEC_SAT_EN  when defined, the scaled comb result is clamped to the
//                   output range. When undefined, it is truncated, so
//                   full-scale +1 wraps to the most negative code.
// -----------------------------------------------------------------------------
module dsm_decimator #(
  parameter int WIDTH    = 16,
  parameter int DEC_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  // Internal modulo width. Integrator wrap is undone by the combs.
  localparam int IW    = 3 * DEC_LOG2 + 2;
  localparam int SHIFT = 3 * DEC_LOG2 - WIDTH + 1;
  // The scaled value is always WIDTH+1 bits wide.
  localparam int SW    = IW - SHIFT;

  localparam logic [DEC_LOG2-1:0] CNT_MAX = {DEC_LOG2{1'b1}};
  localparam logic [DEC_LOG2-1:0] CNT_ONE = {{(DEC_LOG2-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]       X_POS   = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]       X_NEG   = {IW{1'b1}};

  logic [IW-1:0]       x_s;
  logic [IW-1:0]       i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic                dec_stb_q, dec_stb_d;
  logic [IW-1:0]       c1_q, c1_d, c1p_q, c1p_d;
  logic [IW-1:0]       c2_q, c2_d, c2p_q, c2p_d;
  logic [IW-1:0]       c3p_q, c3p_d, c3_s;
  logic                v1_q, v1_d, v2_q, v2_d;
  logic [SW-1:0]       scaled_s;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                unused_s;

`ifdef DSM_DEC_SAT_EN
  // Clamp a WIDTH+1-bit value into the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] sat_fn(input logic [SW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[SW-1] != v[SW-2]) begin
      r = v[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction
`endif

  // Map the bit to +1 / -1 at the internal width.
  assign x_s = in_bit ? X_POS : X_NEG;

  // The last comb stage is combinational and feeds the output register
  // directly. The arithmetic shift is a plain slice of the top bits.
  assign c3_s     = c2_q - c3p_q;
  assign scaled_s = c3_s[IW-1:SHIFT];

  // The bits dropped by scaling are intentionally discarded.
  generate
    if (SHIFT > 0) begin : g_lsb
      assign unused_s = ^{scaled_s[SW-1], c3_s[SHIFT-1:0]};
    end else begin : g_nolsb
      assign unused_s = scaled_s[SW-1];
    end
  endgenerate

  // Next state for the integrators, decimation counter and strobe.
  always_comb begin
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    cnt_d     = cnt_q;
    dec_stb_d = 1'b0;
    if (in_valid) begin
      // Each integrator adds the previous stage's registered value.
      i1_d      = i1_q + x_s;
      i2_d      = i2_q + i1_q;
      i3_d      = i3_q + i2_q;
      cnt_d     = cnt_q + CNT_ONE;
      dec_stb_d = (cnt_q == CNT_MAX);
    end else begin
      dec_stb_d = 1'b0;
    end
  end

  // Next state for the comb pipeline and output. One stage advances per
  // cycle behind the decimation strobe, and in_valid does not stall it.
  always_comb begin
    c1_d        = c1_q;
    c1p_d       = c1p_q;
    c2_d        = c2_q;
    c2p_d       = c2p_q;
    c3p_d       = c3p_q;
    out_d       = out_q;
    v1_d        = dec_stb_q;
    v2_d        = v1_q;
    out_valid_d = v2_q;
    if (dec_stb_q) begin
      c1_d  = i3_q - c1p_q;
      c1p_d = i3_q;
    end else begin
      c1_d  = c1_q;
    end
    if (v1_q) begin
      c2_d  = c1_q - c2p_q;
      c2p_d = c1_q;
    end else begin
      c2_d  = c2_q;
    end
    if (v2_q) begin
      c3p_d = c2_q;
`ifdef DSM_DEC_SAT_EN
      out_d = sat_fn(scaled_s);
`else
      out_d = scaled_s[WIDTH-1:0];
`endif
    end else begin
      out_d = out_q;
    end
  end

  // State registers. Reset also clears the in-flight flags, so aborted
  // comb data never produces a strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i1_q        <= {IW{1'b0}};
      i2_q        <= {IW{1'b0}};
      i3_q        <= {IW{1'b0}};
      cnt_q       <= {DEC_LOG2{1'b0}};
      dec_stb_q   <= 1'b0;
      c1_q        <= {IW{1'b0}};
      c1p_q       <= {IW{1'b0}};
      c2_q        <= {IW{1'b0}};
      c2p_q       <= {IW{1'b0}};
      c3p_q       <= {IW{1'b0}};
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      cnt_q       <= cnt_d;
      dec_stb_q   <= dec_stb_d;
      c1_q        <= c1_d;
      c1p_q       <= c1p_d;
      c2_q        <= c2_d;
      c2p_q       <= c2p_d;
      c3p_q       <= c3p_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsm_decimator.sv
// -----------------------------------------------------------------------------
// tb_dsm_decimator
//   Self-checking bench for dsm_decimator (WIDTH=16, DEC_LOG2=6, R=64).
//   The reference works on accepted bits only:
//     - every 64th accepted bit schedules a strobe 3 clocks later;
//     - a periodic pattern whose period divides 64 settles to
//       mean(+1/-1) * 2^15, saturated or wrapped depending on the build;
//     - a gapped run must reproduce the gapless output sequence.
// -----------------------------------------------------------------------------
module tb_dsm_decimator;

  localparam int W = 16;
  localparam int R = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic [W-1:0] out;
  logic         out_valid;

  always #5 clk = ~clk;

  dsm_decimator #(.WIDTH(W), .DEC_LOG2(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out       (out),
    .out_valid (out_valid)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           acc     = 0;
  int           n_strb  = 0;
  int           expq[$];
  logic [W-1:0] cap[$];
  logic [W-1:0] cap_ref[$];
  logic [W-1:0] last_out;
  logic         chk_val;
  int           exp_val;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected steady-state output of a periodic pattern.
  function automatic int exp_of(input logic [15:0] pat, input int plen);
    int s;
    int v;
    s = 0;
    for (int i = 0; i < plen; i++) s += pat[i] ? 1 : -1;
    v = s * 32768 / plen;
    if (v > 32767) begin
`ifdef DSM_DEC_SAT_EN
      v = 32767;
`else
      v = -32768;
`endif
    end
    return v;
  endfunction

  // One clock: drive inputs, advance the model, check the outputs.
  task automatic step(input logic r, input logic v, input logic b);
    logic exp_stb;
    rst = r; in_valid = v; in_bit = b;
    @(posedge clk);
    cyc++;
    if (!r) begin
      acc = 0; n_strb = 0; expq.delete();
    end else if (v) begin
      acc++;
      if (acc % R == 0) expq.push_back(cyc + 3);
    end
    #1;
    if (!r) begin
      check_eq("rst_out", $signed(out), 0);
      check_eq("rst_vld", out_valid, 0);
      last_out = '0;
    end else begin
      exp_stb = (expq.size() > 0) && (expq[0] == cyc);
      if (exp_stb) void'(expq.pop_front());
      if (out_valid || exp_stb) check_eq("strobe_time", out_valid, exp_stb);
      if (out_valid) begin
        n_strb++;
        cap.push_back(out);
        if (chk_val && n_strb >= 5) check_eq("value", $signed(out), exp_val);
        last_out = out;
      end else if (cyc % 16 == 0) begin
        check_eq("hold", out, last_out);
      end
    end
  endtask

  // Reset, then feed nblk blocks of a repeating pattern; gap_pct is the
  // percentage of cycles with in_valid low.
  task automatic run_pat(input string tag, input logic [15:0] pat,
                         input int plen, input int nblk, input int gap_pct);
    int  k;
    int  idx;
    logic v;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cap.delete();
    chk_val = 1'b1;
    exp_val = exp_of(pat, plen);
    k = 0; idx = 0;
    while (k < nblk * R) begin
      v = ($urandom_range(99) >= gap_pct);
      step(1'b1, v, pat[idx]);
      if (v) begin
        k++;
        idx = (idx + 1) % plen;
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check_eq({tag, "_nstrb"}, n_strb, nblk);
  endtask

  initial begin
    logic [15:0] rp;
    int          rl;
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    last_out = '0; chk_val = 1'b0; exp_val = 0;

    run_pat("zeros", 16'h0000, 1, 20, 0);
    run_pat("ones",  16'h0001, 1, 600, 0);
    run_pat("p10",   16'h0001, 2, 20, 0);
    run_pat("p1110", 16'h0007, 4, 20, 0);
    cap_ref = cap;
    run_pat("gap1110", 16'h0007, 4, 20, 50);
    check_eq("gap_len", cap.size(), cap_ref.size());
    for (int i = 0; i < cap.size() && i < cap_ref.size(); i++)
      check_eq("gap_seq", cap[i], cap_ref[i]);

    for (int t = 0; t < 6; t++) begin
      rl = 1 << $urandom_range(1, 4);
      rp = 16'($urandom);
      run_pat("rand", rp, rl, 12, $urandom_range(0, 1) * 30);
    end

    // Reset after 30 bits of the 2nd block, comb pipeline idle.
    chk_val = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < R + 30; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2 * R; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("rst_mid_nstrb", n_strb, 2);

    // Reset one cycle after the 64th bit, while comb data is in flight.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < R; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("rst_flight_nstrb", n_strb, 0);
    for (int i = 0; i < R; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("rst_flight_after", n_strb, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
